// File: rtl/ram_1rw_byte_mask_pipe.sv
// Single-port RAM with per-byte write mask, 1- or 2-cycle read pipeline and a
// credit-throttled response buffer so read data survives consumer backpressure.
module ram_1rw_byte_mask_pipe #(
  parameter int DATA_W  = 32,
  parameter int BYTE_W  = 8,
  parameter int MASK_W  = DATA_W / BYTE_W,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int OUT_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [MASK_W-1:0] req_mask,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [DATA_W-1:0] resp_data
);

  localparam int LAT   = 1 + OUT_REG;
  localparam int CNT_W = $clog2(LAT + 1);
  localparam int PTR_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(LAT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LAT - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_fire;
  logic              wr_fire;
  logic              resp_fire;
  logic [CNT_W-1:0]  outstanding;

  logic [DATA_W-1:0] data_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_vld;

  logic [DATA_W-1:0] fifo_mem [LAT];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_push;
  logic              fifo_pop;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == LAT_C);

  // Pipeline output bypasses straight to the response port when nothing is queued.
  assign resp_val  = fifo_empty ? pipe_vld : 1'b1;
  assign resp_data = fifo_empty ? pipe_data : fifo_mem[rd_ptr];
  assign resp_fire = resp_val & resp_rdy;

  // A returning response frees a credit in the same cycle, keeping 1 read/cycle.
  always_comb begin
    req_rdy = 1'b0;
    if (!rst) begin
      if (req_wr) req_rdy = 1'b1;
      else        req_rdy = (outstanding < LAT_C) | resp_fire;
    end
  end

  assign rd_fire = req_val & req_rdy & ~req_wr;
  assign wr_fire = req_val & req_rdy & req_wr;

  always_ff @(posedge clk) begin
    for (int i = 0; i < MASK_W; i++) begin
      if (wr_fire && req_mask[i])
        mem[req_addr][i*BYTE_W +: BYTE_W] <= req_data[i*BYTE_W +: BYTE_W];
    end
  end

  // Stage p0: array read registered at the accept edge
  always_ff @(posedge clk) begin
    if (rd_fire) data_p0 <= mem[req_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= rd_fire;
  end

  // Stage p1: optional output register
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;

    always_ff @(posedge clk) begin
      data_p1 <= data_p0;
    end

    always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= vld_p0;
    end

    assign pipe_data = data_p1;
    assign pipe_vld  = vld_p1;
  end else begin : g_no_out_reg
    assign pipe_data = data_p0;
    assign pipe_vld  = vld_p0;
  end

  // Response buffer: absorbs pipeline output whenever it cannot go out directly
  assign fifo_push = pipe_vld & ~(fifo_empty & resp_rdy);
  assign fifo_pop  = ~fifo_empty & resp_rdy;

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= pipe_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({rd_fire, resp_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full));

endmodule

// File: tb/tb_ram_1rw_byte_mask_pipe.sv
// Directed and randomised checks of ram_1rw_byte_mask_pipe, run against both
// OUT_REG=0 (instance 0) and OUT_REG=1 (instance 1).
module tb_ram_1rw_byte_mask_pipe;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_val   [2];
  logic        req_rdy   [2];
  logic        req_wr    [2];
  logic [3:0]  req_addr  [2];
  logic [31:0] req_data  [2];
  logic [3:0]  req_mask  [2];
  logic        resp_val  [2];
  logic        resp_rdy  [2];
  logic [31:0] resp_data [2];

  logic [31:0] model [2][16];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_1rw_byte_mask_pipe #(
      .DATA_W(32), .BYTE_W(8), .DEPTH(16), .OUT_REG(g)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .req_val  (req_val[g]),
      .req_rdy  (req_rdy[g]),
      .req_wr   (req_wr[g]),
      .req_addr (req_addr[g]),
      .req_data (req_data[g]),
      .req_mask (req_mask[g]),
      .resp_val (resp_val[g]),
      .resp_rdy (resp_rdy[g]),
      .resp_data(resp_data[g])
    );
  end

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] expd;
  } vec_t;

  vec_t vt [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expd);
    total++;
    if (act !== expd) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, expd);
    end
  endtask

  task automatic set_idle(input int d);
    req_val[d]  = 1'b0;
    req_wr[d]   = 1'b0;
    req_addr[d] = 4'd0;
    req_data[d] = 32'd0;
    req_mask[d] = 4'd0;
  endtask

  task automatic do_write(input int d, input logic [3:0] a, input logic [31:0] data,
                          input logic [3:0] mask);
    req_val[d]  = 1'b1;
    req_wr[d]   = 1'b1;
    req_addr[d] = a;
    req_data[d] = data;
    req_mask[d] = mask;
    @(negedge clk);
    check($sformatf("wr_rdy_d%0d", d), {31'b0, req_rdy[d]}, 32'd1);
    for (int i = 0; i < 4; i++)
      if (mask[i]) model[d][a][i*8 +: 8] = data[i*8 +: 8];
    tick();
    set_idle(d);
  endtask

  // Single read with resp_rdy held high: response must appear exactly LAT cycles later.
  task automatic read_check(input int d, input logic [3:0] a, input logic [31:0] expd,
                            input string name);
    int lat;
    lat = 1 + d;
    resp_rdy[d] = 1'b1;
    req_val[d]  = 1'b1;
    req_wr[d]   = 1'b0;
    req_addr[d] = a;
    @(negedge clk);
    check({name, "_rdy"}, {31'b0, req_rdy[d]}, 32'd1);
    tick();
    set_idle(d);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check($sformatf("%s_val_c%0d", name, k), {31'b0, resp_val[d]}, {31'b0, (k == lat)});
      if (k == lat) check({name, "_data"}, resp_data[d], expd);
      tick();
    end
  endtask

  // resp_rdy low: exactly LAT reads accepted, then held data drained in order.
  task automatic backpressure(input int d, input logic [3:0] base);
    int lat;
    int acc;
    logic [31:0] q[$];
    lat = 1 + d;
    acc = 0;
    resp_rdy[d] = 1'b0;
    for (int c = 0; c < lat + 3; c++) begin
      req_val[d]  = 1'b1;
      req_wr[d]   = 1'b0;
      req_addr[d] = base + 4'(acc);
      @(negedge clk);
      if (req_rdy[d]) begin
        q.push_back(model[d][base + 4'(acc)]);
        acc++;
      end
      tick();
    end
    set_idle(d);
    check($sformatf("bp_accepted_d%0d", d), 32'(acc), 32'(lat));
    @(negedge clk);
    check($sformatf("bp_hold_val_d%0d", d), {31'b0, resp_val[d]}, 32'd1);
    if (q.size() > 0) check($sformatf("bp_hold_data_d%0d", d), resp_data[d], q[0]);
    tick();
    resp_rdy[d] = 1'b1;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      check($sformatf("bp_drain_val%0d_d%0d", k, d), {31'b0, resp_val[d]}, 32'd1);
      check($sformatf("bp_drain_data%0d_d%0d", k, d), resp_data[d], q[k]);
      tick();
    end
    @(negedge clk);
    check($sformatf("bp_empty_d%0d", d), {31'b0, resp_val[d]}, 32'd0);
    tick();
  endtask

  task automatic random_test(input int d, input int n);
    int lat;
    logic [31:0] q[$];
    logic prev_stall;
    lat = 1 + d;
    prev_stall = 1'b0;
    for (int a = 0; a < 16; a++) do_write(d, 4'(a), $urandom, 4'hF);
    for (int c = 0; c < n; c++) begin
      req_val[d]  = ($urandom_range(0, 99) < 60);
      req_wr[d]   = 1'($urandom_range(0, 1));
      req_addr[d] = 4'($urandom_range(0, 15));
      req_data[d] = $urandom;
      req_mask[d] = 4'($urandom_range(0, 15));
      resp_rdy[d] = ($urandom_range(0, 99) < 55);
      @(negedge clk);
      if (req_wr[d] || q.size() < lat)
        check($sformatf("rnd_rdy_c%0d_d%0d", c, d), {31'b0, req_rdy[d]}, 32'd1);
      else if (!resp_rdy[d])
        check($sformatf("rnd_rdy_c%0d_d%0d", c, d), {31'b0, req_rdy[d]}, 32'd0);
      if (prev_stall)
        check($sformatf("rnd_hold_c%0d_d%0d", c, d), {31'b0, resp_val[d]}, 32'd1);
      if (resp_val[d]) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rnd_spurious_c%0d_d%0d: got resp_val=1, expected 0", c, d);
        end else begin
          check($sformatf("rnd_data_c%0d_d%0d", c, d), resp_data[d], q[0]);
          if (resp_rdy[d]) void'(q.pop_front());
        end
      end
      if (req_val[d] && req_rdy[d]) begin
        if (req_wr[d]) begin
          for (int i = 0; i < 4; i++)
            if (req_mask[d][i]) model[d][req_addr[d]][i*8 +: 8] = req_data[d][i*8 +: 8];
        end else begin
          q.push_back(model[d][req_addr[d]]);
        end
      end
      prev_stall = resp_val[d] && !resp_rdy[d];
      tick();
    end
    set_idle(d);
    resp_rdy[d] = 1'b1;
    for (int c = 0; c < 8 && q.size() > 0; c++) begin
      @(negedge clk);
      if (resp_val[d]) begin
        check($sformatf("rnd_drain_d%0d", d), resp_data[d], q[0]);
        void'(q.pop_front());
      end
      tick();
    end
    check($sformatf("rnd_leftover_d%0d", d), 32'(q.size()), 32'd0);
    @(negedge clk);
    check($sformatf("rnd_final_val_d%0d", d), {31'b0, resp_val[d]}, 32'd0);
    tick();
  endtask

  initial begin
    vt[0]  = '{1'b1, 4'd5,  32'hAABBCCDD, 4'hF, 32'h0};
    vt[1]  = '{1'b0, 4'd5,  32'h0,        4'h0, 32'hAABBCCDD};
    vt[2]  = '{1'b1, 4'd5,  32'h11223344, 4'h5, 32'h0};
    vt[3]  = '{1'b0, 4'd5,  32'h0,        4'h0, 32'hAA22CC44};
    vt[4]  = '{1'b1, 4'd5,  32'hFFFFFFFF, 4'h0, 32'h0};
    vt[5]  = '{1'b0, 4'd5,  32'h0,        4'h0, 32'hAA22CC44};
    vt[6]  = '{1'b1, 4'd0,  32'hC0DE0000, 4'hF, 32'h0};
    vt[7]  = '{1'b1, 4'd7,  32'hC0DE0007, 4'hF, 32'h0};
    vt[8]  = '{1'b1, 4'd7,  32'h12345678, 4'h8, 32'h0};
    vt[9]  = '{1'b0, 4'd7,  32'h0,        4'h0, 32'h12DE0007};
    vt[10] = '{1'b1, 4'd0,  32'hFFFFFFFF, 4'h1, 32'h0};
    vt[11] = '{1'b0, 4'd0,  32'h0,        4'h0, 32'hC0DE00FF};
    vt[12] = '{1'b1, 4'd15, 32'h0F0F0F0F, 4'hF, 32'h0};
    vt[13] = '{1'b1, 4'd15, 32'hA5A5A5A5, 4'h6, 32'h0};
    vt[14] = '{1'b0, 4'd15, 32'h0,        4'h0, 32'h0FA5A50F};
    vt[15] = '{1'b0, 4'd0,  32'h0,        4'h0, 32'hC0DE00FF};

    for (int d = 0; d < 2; d++) begin
      set_idle(d);
      rst[d]      = 1'b1;
      resp_rdy[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_rdy_d%0d", d), {31'b0, req_rdy[d]}, 32'd0);
      check($sformatf("rst_val_d%0d", d), {31'b0, resp_val[d]}, 32'd0);
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("post_rst_rdy_d%0d", d), {31'b0, req_rdy[d]}, 32'd1);
      check($sformatf("post_rst_val_d%0d", d), {31'b0, resp_val[d]}, 32'd0);
    end
    tick();

    for (int d = 0; d < 2; d++) begin
      int lat;
      lat = 1 + d;

      for (int i = 0; i < 16; i++) begin
        if (vt[i].wr) do_write(d, vt[i].addr, vt[i].data, vt[i].mask);
        else          read_check(d, vt[i].addr, vt[i].expd, $sformatf("tbl%0d_d%0d", i, d));
      end

      // Back-to-back streaming reads with resp_rdy held high.
      for (int a = 0; a < 8; a++) do_write(d, 4'(a), 32'h5A000000 + 32'(a) * 32'h00010101, 4'hF);
      resp_rdy[d] = 1'b1;
      for (int c = 0; c < 8 + lat; c++) begin
        if (c < 8) begin
          req_val[d]  = 1'b1;
          req_wr[d]   = 1'b0;
          req_addr[d] = 4'(c);
        end else begin
          set_idle(d);
        end
        @(negedge clk);
        if (c < 8) check($sformatf("b2b_rdy%0d_d%0d", c, d), {31'b0, req_rdy[d]}, 32'd1);
        check($sformatf("b2b_val%0d_d%0d", c, d), {31'b0, resp_val[d]}, {31'b0, (c >= lat)});
        if (c >= lat)
          check($sformatf("b2b_data%0d_d%0d", c - lat, d), resp_data[d],
                32'h5A000000 + 32'(c - lat) * 32'h00010101);
        tick();
      end

      backpressure(d, 4'd0);

      // Reset with reads in flight: nothing must come out, credits restart at zero.
      resp_rdy[d] = 1'b0;
      for (int c = 0; c < lat; c++) begin
        req_val[d]  = 1'b1;
        req_wr[d]   = 1'b0;
        req_addr[d] = 4'(c + 2);
        @(negedge clk);
        check($sformatf("rstf_acc%0d_d%0d", c, d), {31'b0, req_rdy[d]}, 32'd1);
        tick();
      end
      rst[d]      = 1'b1;
      req_addr[d] = 4'd3;
      @(negedge clk);
      check($sformatf("rstf_rdy_d%0d", d), {31'b0, req_rdy[d]}, 32'd0);
      tick();
      rst[d] = 1'b0;
      set_idle(d);
      resp_rdy[d] = 1'b1;
      for (int k = 0; k < lat + 2; k++) begin
        @(negedge clk);
        check($sformatf("rstf_noresp%0d_d%0d", k, d), {31'b0, resp_val[d]}, 32'd0);
        tick();
      end
      backpressure(d, 4'd4);
      read_check(d, 4'd5, 32'h5A050505, $sformatf("rstf_keep_d%0d", d));

      random_test(d, 400);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
